// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage.
// Request is valid/ready; the read response is valid-only.
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic              dmem_req_we;
    logic [ADDR_W-1:0] dmem_req_addr;
    logic [31:0]       dmem_req_wdata;
    logic [3:0]        dmem_req_wstrb;
    logic              dmem_rsp_valid;
    logic [31:0]       dmem_rsp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr,
        output dmem_req_wdata, dmem_req_wstrb,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr,
        input  dmem_req_wdata, dmem_req_wstrb,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: load/store sequencing against dmem,
// sub-word formatting, misalignment trap and writeback mux.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    mem_stage_if.master dmem,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        stall_en,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              rw_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       ldata_q;

    logic        is_mem, is_st, byte_op, half_op, mis;
    logic [1:0]  off;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        latch, ld_cap;

    // Decode the EX op: access size, alignment and store lane formatting.
    always_comb begin
        off      = ex_alu_result[1:0];
        is_mem   = ex_valid & (ex_mem_read | ex_mem_write);
        is_st    = ex_mem_write & ~ex_mem_read;
        byte_op  = is_st ? (ex_funct3 == 3'b000)
                         : (ex_funct3[1:0] == 2'b00);
        half_op  = is_st ? (ex_funct3 == 3'b001)
                         : (ex_funct3[1:0] == 2'b01);
        mis      = half_op ? off[0] : (byte_op ? 1'b0 : (off != 2'b00));
        st_wdata = ex_rs2_data;
        st_wstrb = 4'b1111;
        unique case (1'b1)
            byte_op: begin
                st_wdata = {4{ex_rs2_data[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            half_op: begin
                st_wdata = {2{ex_rs2_data[15:0]}};
                st_wstrb = 4'b0011 << off;
            end
            default: ;
        endcase
    end

    // Extract and extend the load result from the response word.
    always_comb begin
        ld_byte = 8'h00;
        unique case (off_q)
            2'd0: ld_byte = dmem.dmem_rsp_rdata[7:0];
            2'd1: ld_byte = dmem.dmem_rsp_rdata[15:8];
            2'd2: ld_byte = dmem.dmem_rsp_rdata[23:16];
            2'd3: ld_byte = dmem.dmem_rsp_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem.dmem_rsp_rdata[31:16]
                           : dmem.dmem_rsp_rdata[15:0];
        ld_val  = dmem.dmem_rsp_rdata;
        unique case (1'b1)
            f3_q[1:0] == 2'b00:
                ld_val = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
            f3_q[1:0] == 2'b01:
                ld_val = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

    // Next state, handshake and writeback outputs.
    always_comb begin
        state_d             = state_q;
        latch               = 1'b0;
        ld_cap              = 1'b0;
        dmem.dmem_req_valid = 1'b0;
        stall_en            = 1'b0;
        wb_valid            = 1'b0;
        wb_rd               = ex_rd;
        wb_reg_write        = 1'b0;
        wb_data             = 32'h0;
        misalign            = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ex_valid && !is_mem) begin
                    wb_valid     = 1'b1;
                    wb_reg_write = ex_reg_write;
                    wb_data      = ex_alu_result;
                end else if (is_mem && mis) begin
                    wb_valid = 1'b1;
                    misalign = 1'b1;
                end else if (is_mem) begin
                    latch    = 1'b1;
                    stall_en = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                dmem.dmem_req_valid = 1'b1;
                stall_en            = 1'b1;
                wb_rd               = rd_q;
                if (dmem.dmem_req_ready)
                    state_d = we_q ? DONE : RSP;
            end
            RSP: begin
                stall_en = 1'b1;
                wb_rd    = rd_q;
                if (dmem.dmem_rsp_valid) begin
                    ld_cap  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                wb_valid     = 1'b1;
                wb_rd        = rd_q;
                wb_reg_write = rw_q & ~we_q;
                wb_data      = we_q ? 32'h0 : ldata_q;
                state_d      = IDLE;
            end
        endcase
        if (ARESET) begin
            dmem.dmem_req_valid = 1'b0;
            stall_en            = 1'b0;
            wb_valid            = 1'b0;
            wb_reg_write        = 1'b0;
            misalign            = 1'b0;
        end
    end

    assign dmem.dmem_req_we    = we_q;
    assign dmem.dmem_req_addr  = addr_q;
    assign dmem.dmem_req_wdata = wdata_q;
    assign dmem.dmem_req_wstrb = wstrb_q;

    // FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request payload and load result, held stable across the access.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            addr_q  <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ldata_q <= '0;
        end else begin
            if (latch) begin
                addr_q  <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                off_q   <= off;
                f3_q    <= ex_funct3;
                rd_q    <= ex_rd;
                rw_q    <= ex_reg_write;
                we_q    <= is_st;
                wdata_q <= st_wdata;
                wstrb_q <= st_wstrb;
            end
            if (ld_cap) ldata_q <= ld_val;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard.
// Expected writebacks are queued at issue and popped on wb_valid.
module tb_mem_stage;
    logic        ACLK;
    logic        ARESET;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        wb_valid, wb_reg_write, stall_en, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mem_stage_if #(.ADDR_W(32)) dmem_if ();

    mem_stage #(.ADDR_W(32)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_funct3     (ex_funct3),
        .ex_alu_result (ex_alu_result),
        .ex_rs2_data   (ex_rs2_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .dmem          (dmem_if),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .stall_en      (stall_en),
        .misalign      (misalign)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   hs_cnt = 0;
    int   hs0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic rw,
                        input logic [31:0] data, input logic mis);
        exp_t e;
        e.rd = rd; e.rw = rw; e.data = data; e.mis = mis;
        sb.push_back(e);
    endtask

    // Sample at the falling edge; pop scoreboard on writeback.
    task automatic obs();
        exp_t e;
        @(negedge ACLK);
        if (dmem_if.dmem_req_valid && dmem_if.dmem_req_ready) hs_cnt++;
        if (wb_valid) begin
            if (sb.size() == 0) begin
                chk("sb_extra_wb", {31'h0, wb_valid}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("sb_reg_write", {31'h0, wb_reg_write}, {31'h0, e.rw});
                chk("sb_misalign", {31'h0, misalign}, {31'h0, e.mis});
                if (!e.mis) begin
                    chk("sb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
                    chk("sb_data", wb_data, e.data);
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic rd_, input logic wr_,
                          input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [4:0] rd,
                          input logic rw);
        ex_valid = v; ex_mem_read = rd_; ex_mem_write = wr_;
        ex_funct3 = f3; ex_alu_result = alu; ex_rs2_data = rs2;
        ex_rd = rd; ex_reg_write = rw;
    endtask

    initial begin
        ARESET = 1'b1;
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        dmem_if.dmem_req_ready = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b0;
        dmem_if.dmem_rsp_rdata = 32'h0;

        // reset state
        obs();
        chk("rst_req_valid", {31'h0, dmem_if.dmem_req_valid}, 32'h0);
        chk("rst_stall", {31'h0, stall_en}, 32'h0);
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_wb_rw", {31'h0, wb_reg_write}, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        adv();
        ARESET = 1'b0;
        obs();
        adv();

        // ALU passthrough, same cycle
        set_ex(1, 0, 0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 1);
        push(5'd5, 1, 32'h1234_5678, 0);
        obs();
        chk("alu_wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("alu_stall", {31'h0, stall_en}, 32'h0);
        adv();
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        obs();
        chk("idle_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("idle_stall", {31'h0, stall_en}, 32'h0);
        adv();

        // LB at 0x103, rsp after one wait cycle
        hs0 = hs_cnt;
        set_ex(1, 1, 0, 3'b000, 32'h103, 32'h0, 5'd7, 1);
        push(5'd7, 1, 32'hFFFF_FF80, 0);
        dmem_if.dmem_req_ready = 1'b1;
        obs();
        chk("lb_issue_stall", {31'h0, stall_en}, 32'h1);
        chk("lb_issue_wbv", {31'h0, wb_valid}, 32'h0);
        chk("lb_issue_reqv", {31'h0, dmem_if.dmem_req_valid}, 32'h0);
        adv();
        obs();
        chk("lb_req_valid", {31'h0, dmem_if.dmem_req_valid}, 32'h1);
        chk("lb_req_addr", dmem_if.dmem_req_addr, 32'h100);
        chk("lb_req_we", {31'h0, dmem_if.dmem_req_we}, 32'h0);
        chk("lb_req_stall", {31'h0, stall_en}, 32'h1);
        adv();
        dmem_if.dmem_req_ready = 1'b0;
        obs();
        chk("lb_rsp_stall", {31'h0, stall_en}, 32'h1);
        chk("lb_rsp_reqv", {31'h0, dmem_if.dmem_req_valid}, 32'h0);
        adv();
        dmem_if.dmem_rsp_valid = 1'b1;
        dmem_if.dmem_rsp_rdata = 32'h80FF_1234;
        obs();
        chk("lb_rsp2_stall", {31'h0, stall_en}, 32'h1);
        adv();
        dmem_if.dmem_rsp_valid = 1'b0;
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        obs();
        chk("lb_done_wbv", {31'h0, wb_valid}, 32'h1);
        chk("lb_done_stall", {31'h0, stall_en}, 32'h0);
        adv();
        chk("lb_one_req", hs_cnt - hs0, 32'd1);

        // SH at 0x202, ready after 3 wait cycles
        hs0 = hs_cnt;
        set_ex(1, 0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd9, 1);
        push(5'd9, 0, 32'h0, 0);
        obs();
        chk("sh_issue_stall", {31'h0, stall_en}, 32'h1);
        adv();
        for (int i = 0; i < 4; i++) begin
            dmem_if.dmem_req_ready = (i == 3);
            obs();
            chk("sh_req_valid", {31'h0, dmem_if.dmem_req_valid}, 32'h1);
            chk("sh_req_addr", dmem_if.dmem_req_addr, 32'h200);
            chk("sh_req_we", {31'h0, dmem_if.dmem_req_we}, 32'h1);
            chk("sh_wdata", dmem_if.dmem_req_wdata, 32'hABCD_ABCD);
            chk("sh_wstrb", {28'h0, dmem_if.dmem_req_wstrb}, 32'hC);
            chk("sh_stall", {31'h0, stall_en}, 32'h1);
            adv();
        end
        dmem_if.dmem_req_ready = 1'b0;
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        obs();
        chk("sh_done_wbv", {31'h0, wb_valid}, 32'h1);
        chk("sh_done_stall", {31'h0, stall_en}, 32'h0);
        adv();
        chk("sh_one_req", hs_cnt - hs0, 32'd1);

        // SB at 0x301: byte lane 1
        set_ex(1, 0, 1, 3'b000, 32'h301, 32'h1234_565A, 5'd2, 1);
        push(5'd2, 0, 32'h0, 0);
        dmem_if.dmem_req_ready = 1'b1;
        obs();
        adv();
        obs();
        chk("sb_wdata", dmem_if.dmem_req_wdata, 32'h5A5A_5A5A);
        chk("sb_wstrb", {28'h0, dmem_if.dmem_req_wstrb}, 32'h2);
        chk("sb_addr", dmem_if.dmem_req_addr, 32'h300);
        adv();
        dmem_if.dmem_req_ready = 1'b0;
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        obs();
        adv();

        // LW at 0x006 traps as misaligned
        hs0 = hs_cnt;
        set_ex(1, 1, 0, 3'b010, 32'h6, 32'h0, 5'd3, 1);
        push(5'd3, 0, 32'h0, 1);
        obs();
        chk("lw_mis_wbv", {31'h0, wb_valid}, 32'h1);
        chk("lw_mis_stall", {31'h0, stall_en}, 32'h0);
        chk("lw_mis_reqv", {31'h0, dmem_if.dmem_req_valid}, 32'h0);
        adv();
        set_ex(1, 0, 1, 3'b001, 32'h11, 32'h0, 5'd3, 0);
        push(5'd3, 0, 32'h0, 1);
        obs();
        chk("sh_mis_stall", {31'h0, stall_en}, 32'h0);
        adv();
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        obs();
        chk("mis_no_req", {31'h0, dmem_if.dmem_req_valid}, 32'h0);
        chk("mis_no_hs", hs_cnt - hs0, 32'd0);
        adv();

        // reset while waiting in RSP, late response ignored
        set_ex(1, 1, 0, 3'b010, 32'h40, 32'h0, 5'd4, 1);
        dmem_if.dmem_req_ready = 1'b1;
        obs();
        adv();
        obs();
        adv();
        dmem_if.dmem_req_ready = 1'b0;
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        ARESET = 1'b1;
        obs();
        chk("rstrsp_stall", {31'h0, stall_en}, 32'h0);
        chk("rstrsp_wbv", {31'h0, wb_valid}, 32'h0);
        adv();
        ARESET = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b1;
        dmem_if.dmem_rsp_rdata = 32'hDEAD_BEEF;
        obs();
        chk("late_rsp_wbv", {31'h0, wb_valid}, 32'h0);
        chk("late_rsp_stall", {31'h0, stall_en}, 32'h0);
        chk("late_rsp_reqv", {31'h0, dmem_if.dmem_req_valid}, 32'h0);
        adv();
        dmem_if.dmem_rsp_valid = 1'b0;
        obs();
        chk("late_rsp_wbv2", {31'h0, wb_valid}, 32'h0);
        adv();

        // LHU at 0x12, EX held through DONE
        hs0 = hs_cnt;
        set_ex(1, 1, 0, 3'b101, 32'h12, 32'h0, 5'd10, 1);
        push(5'd10, 1, 32'h0000_BEEF, 0);
        dmem_if.dmem_req_ready = 1'b1;
        obs();
        adv();
        obs();
        adv();
        dmem_if.dmem_req_ready = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b1;
        dmem_if.dmem_rsp_rdata = 32'hBEEF_0000;
        obs();
        adv();
        dmem_if.dmem_rsp_valid = 1'b0;
        obs();
        chk("lhu_done_wbv", {31'h0, wb_valid}, 32'h1);
        chk("lhu_done_reqv", {31'h0, dmem_if.dmem_req_valid}, 32'h0);
        chk("lhu_done_stall", {31'h0, stall_en}, 32'h0);
        adv();
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        obs();
        chk("lhu_one_req", hs_cnt - hs0, 32'd1);
        chk("lhu_after_wbv", {31'h0, wb_valid}, 32'h0);
        adv();

        // LH at 0x22, sign-extended upper half
        set_ex(1, 1, 0, 3'b001, 32'h22, 32'h0, 5'd11, 1);
        push(5'd11, 1, 32'hFFFF_8001, 0);
        dmem_if.dmem_req_ready = 1'b1;
        obs();
        adv();
        obs();
        adv();
        dmem_if.dmem_req_ready = 1'b0;
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        dmem_if.dmem_rsp_valid = 1'b1;
        dmem_if.dmem_rsp_rdata = 32'h8001_7777;
        obs();
        adv();
        dmem_if.dmem_rsp_valid = 1'b0;
        obs();
        adv();
        obs();
        adv();

        chk("sb_leftover", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the data-memory byte-address width.
REQ-002 ACLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 ARESET  input  1  SHALL be a synchronous, active-high reset.
REQ-004 ex_valid  input  1  SHALL qualify the EX/MEM instruction.
REQ-005 ex_mem_read / ex_mem_write  input  1 each  SHALL mark load / store; both high is treated as load.
REQ-006 ex_funct3  input  3  SHALL select access size and sign.
REQ-007 ex_alu_result  input  32  SHALL carry the effective address, or the writeback value for non-memory ops.
REQ-008 ex_rs2_data  input  32  SHALL carry store data.
REQ-009 ex_rd  input  5, ex_reg_write  input  1  SHALL carry the destination register and write enable.
REQ-010 dmem_req_valid / dmem_req_ready  output / input  1  SHALL form the memory request handshake.
REQ-011 dmem_req_we  output  1, dmem_req_addr  output  ADDR_W, dmem_req_wdata  output  32, dmem_req_wstrb  output  4  SHALL form the request payload; the address is word-aligned (bits [1:0]=0).
REQ-012 dmem_rsp_valid  input  1, dmem_rsp_rdata  input  32  SHALL carry the read response.
REQ-013 wb_valid  output  1, wb_rd  output  5, wb_reg_write  output  1, wb_data  output  32  SHALL feed the MEM/WB register combinationally.
REQ-014 stall_en  output  1  SHALL hold the upstream stages and the MEM/WB register.
REQ-015 misalign  output  1  SHALL flag a misaligned access for one completion cycle.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, RSP, and DONE.
REQ-017 Non-memory op in IDLE: wb_valid=ex_valid, wb_data=ex_alu_result, wb_rd/wb_reg_write pass through, stall_en=0, all in the same cycle.
REQ-018 Aligned memory op in IDLE SHALL do the following:
  - latch the word address, the byte offset addr[1:0], funct3, rd, reg_write, we, wdata, and wstrb;
  - drive stall_en=1 and wb_valid=0;
  - go to REQ.
REQ-019 REQ SHALL hold dmem_req_valid=1 with a stable payload until dmem_req_ready=1; stall_en=1 throughout.
REQ-020 Handshake in REQ SHALL go to DONE for a store and to RSP for a load.
REQ-021 RSP SHALL keep stall_en=1 and wait for dmem_rsp_valid. On response it SHALL latch the extracted load data and go to DONE.
REQ-022 DONE SHALL last exactly one cycle and then go to IDLE. It SHALL drive:
  - stall_en=0 and wb_valid=1;
  - latched rd and reg_write; reg_write is forced to 0 for stores;
  - wb_data = the load result for loads, 0 for stores.
REQ-023 DONE SHALL NOT start a new request even though the same EX inputs are still present.
REQ-024 Load extraction by funct3 SHALL be:
  - 000 LB: byte at offset, sign-extended;
  - 100 LBU: byte at offset, zero-extended;
  - 001 LH: half at offset[1], sign-extended;
  - 101 LHU: half at offset[1], zero-extended;
  - 010 LW and any other code: full word.
REQ-025 Store formatting by funct3 SHALL be:
  - SB: wdata = byte replicated x4, wstrb = 4'b0001<<offset;
  - SH: wdata = half replicated x2, wstrb = 4'b0011<<offset;
  - SW and any other code: wdata = rs2, wstrb = 4'b1111.
REQ-026 Misalignment SHALL be detected as follows:
  - LW/SW misaligned when addr[1:0]!=0;
  - LH/LHU/SH misaligned when addr[0]!=0;
  - on a misaligned op, no request is issued, the FSM stays in IDLE, and the same cycle drives wb_valid=1, wb_reg_write=0, misalign=1, stall_en=0.
REQ-027 dmem_rsp_valid outside RSP SHALL be ignored.
REQ-028 dmem_req_valid SHALL be 0 in every state other than REQ.
REQ-029 ex_valid=0 in IDLE SHALL produce wb_valid=0 and stall_en=0, with no state change.

Reset
REQ-030 ARESET=1 at a clock edge SHALL force IDLE and clear all latched fields to 0.
REQ-031 During reset, outputs SHALL be: dmem_req_valid=0, stall_en=0, wb_valid=0, wb_reg_write=0, misalign=0.
REQ-032 Reset mid-REQ or mid-RSP SHALL abandon the access: dmem_req_valid drops in the cycle after the reset edge, and any later response is ignored.

Verification
REQ-033 LB at addr 0x103 with rdata 0x80FF_1234 -> one request to addr 0x100 with we=0; wb_data=0xFFFF_FF80 in DONE; stall_en high from the issue cycle through the RSP cycles.
REQ-034 SH at addr 0x202 with rs2=0x0000_ABCD, ready delayed 3 cycles -> wdata=0xABCD_ABCD and wstrb=4'b1100 held stable for 4 cycles; DONE has wb_reg_write=0.
REQ-035 LW at addr 0x006 -> misalign=1, dmem_req_valid never rises, stall_en=0, wb_valid=1, wb_reg_write=0.
REQ-036 ALU op with ex_alu_result=0x1234_5678, rd=5 -> wb_data=0x1234_5678 and wb_rd=5 in the same cycle, no stall.
REQ-037 ARESET asserted while in RSP, then a response arrives -> FSM in IDLE, response ignored, wb_valid=0.
REQ-038 LHU at addr 0x12 with rsp_valid in the first RSP cycle and rdata 0xBEEF_0000 -> wb_data=0x0000_BEEF; exactly one request is issued even though the EX inputs are held through DONE.
